// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared definitions for the pipeline control slice:
//     - stall vector width and per-stage bit indices
//     - Stop / NoStop stall-bit values and the reset-asserted level
//     - memory port arbiter state encodings
//     - stall source enum plus helpers (stall mask, arbitration, saturating
//       increment)
//   No ports (package).
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  // Stall vector layout, youngest stage in bit 0.
  localparam int StallWidth  = 6;
  localparam int StallPcBit  = 0;
  localparam int StallIfBit  = 1;
  localparam int StallIdBit  = 2;
  localparam int StallExBit  = 3;
  localparam int StallMemBit = 4;
  localparam int StallWbBit  = 5;

  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;

  // Reset is active-low.
  localparam logic RstEnable = 1'b0;

  // Memory port arbiter state encodings.
  localparam logic [1:0] ArbIdle   = 2'b00;
  localparam logic [1:0] ArbGntIf  = 2'b01;
  localparam logic [1:0] ArbGntMem = 2'b10;

  // Highest-priority reason the pipeline is being held this cycle.
  typedef enum logic [2:0] {
    StallSrcNone,
    StallSrcIf,
    StallSrcId,
    StallSrcEx,
    StallSrcMem
  } stall_src_e;

  // A stall originating in a stage stops that stage and every younger one,
  // so the mask is all Stop from bit 0 up to the requesting stage.
  function automatic logic [StallWidth-1:0] stall_mask(stall_src_e src);
    int last;
    logic [StallWidth-1:0] m;
    case (src)
      StallSrcMem: last = StallMemBit;
      StallSrcEx:  last = StallExBit;
      StallSrcId:  last = StallIdBit;
      StallSrcIf:  last = StallIfBit;
      default:     last = -1;
    endcase
    for (int i = 0; i < StallWidth; i++) begin
      m[i] = (i <= last) ? Stop : NoStop;
    end
    return m;
  endfunction

  // Memory stage wins over fetch when both are requesting.
  function automatic logic [1:0] arbitrate(logic if_req, logic mem_req);
    if (mem_req) begin
      return ArbGntMem;
    end else if (if_req) begin
      return ArbGntIf;
    end
    return ArbIdle;
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_mem_port_arb.sv
// ---------------------------------------------------------------------------
// mem_port_arb
//   Arbiter for the single memory port shared by instruction fetch and the
//   MEM stage. Once granted, ownership is held until bus_ack completes the
//   transaction, then re-arbitrated on that same edge (no idle bubble).
//   Ports:
//     clk        - clock
//     rst        - asynchronous active-low reset
//     if_req     - fetch wants the port
//     mem_req    - load/store wants the port
//     bus_ack    - one-cycle completion pulse for the granted transaction
//     grant_if   - port owned by fetch
//     grant_mem  - port owned by MEM stage
// ---------------------------------------------------------------------------
module mem_port_arb
  import pipeline_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic mem_req,
  input  logic bus_ack,
  output logic grant_if,
  output logic grant_mem
);

  logic [1:0] state_q, state_d;

  // Next-state: IDLE arbitrates every cycle (a stray ack there means
  // nothing); a granted state only moves on when its transaction completes,
  // so requests arriving mid-transaction cannot steal the port.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ArbIdle: begin
        state_d = arbitrate(if_req, mem_req);
      end
      ArbGntIf, ArbGntMem: begin
        if (bus_ack) begin
          state_d = arbitrate(if_req, mem_req);
        end
      end
      default: begin
        state_d = ArbIdle;
      end
    endcase
  end

  // State register; reset abandons any grant in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ArbIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign grant_if  = (state_q == ArbGntIf);
  assign grant_mem = (state_q == ArbGntMem);

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Pipeline stall/flush controller for a 6-stage pipeline sharing one
//   memory port between IF and MEM.
//   Ports:
//     clk           - clock
//     rst           - asynchronous active-low reset
//     stallreq_id   - ID load-use hazard stall request
//     stallreq_ex   - EX multi-cycle operation stall request
//     if_req        - fetch requests memory port
//     mem_req       - MEM stage requests memory port
//     bus_ack       - granted memory transaction completes this cycle
//     branch_flag   - EX resolved a taken branch/jump
//     grant_if      - memory port owned by IF
//     grant_mem     - memory port owned by MEM
//     stall[5:0]    - per-stage stop (0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB)
//     flush         - kill IF/ID contents this cycle
//     stall_cycles  - number of cycles with any stage stopped (saturating)
//   Configuration:
//     PIPE_CTRL_PERF_EN - when defined, builds the stall_cycles counter;
//                         otherwise stall_cycles is tied to zero.
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stallreq_id,
  input  logic                  stallreq_ex,
  input  logic                  if_req,
  input  logic                  mem_req,
  input  logic                  bus_ack,
  input  logic                  branch_flag,
  output logic                  grant_if,
  output logic                  grant_mem,
  output logic [StallWidth-1:0] stall,
  output logic                  flush,
  output logic [31:0]           stall_cycles
);

  logic       mem_wait;
  logic       if_wait;
  stall_src_e stall_src;

  mem_port_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .mem_req   (mem_req),
    .bus_ack   (bus_ack),
    .grant_if  (grant_if),
    .grant_mem (grant_mem)
  );

  // A requester is only waiting if it is not the owner being acked right
  // now, which releases the stall in the very cycle the ack arrives.
  assign mem_wait = mem_req && !(grant_mem && bus_ack);
  assign if_wait  = if_req  && !(grant_if  && bus_ack);

  // Oldest stage asking to hold wins; its mask covers all younger stages.
  always_comb begin
    stall_src = StallSrcNone;
    if (mem_wait) begin
      stall_src = StallSrcMem;
    end else if (stallreq_ex) begin
      stall_src = StallSrcEx;
    end else if (stallreq_id) begin
      stall_src = StallSrcId;
    end else if (if_wait) begin
      stall_src = StallSrcIf;
    end
  end

  // Outputs are forced quiet while reset is held, without waiting for a clock.
  // A taken branch lives in EX, so it can only be lost to a hold of EX or
  // older; ID/IF holds are overridden because those instructions die anyway.
  assign stall = (rst == RstEnable) ? '0 : stall_mask(stall_src);
  assign flush = (rst != RstEnable) && branch_flag && !mem_wait && !stallreq_ex;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall != '0) begin
      stall_cycles_d = sat_inc(stall_cycles_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'h0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-low (rst==0 resets).
REQ-003 stallreq_id  input  1  ID load-use hazard stall request.
REQ-004 stallreq_ex  input  1  EX multi-cycle operation stall request.
REQ-005 if_req  input  1  instruction fetch requests shared memory port.
REQ-006 mem_req  input  1  MEM stage load/store requests shared memory port.
REQ-007 bus_ack  input  1  one-cycle pulse: granted memory transaction complete.
REQ-008 branch_flag  input  1  EX resolved taken branch/jump.
REQ-009 grant_if  output  1  memory port owned by IF.
REQ-010 grant_mem  output  1  memory port owned by MEM.
REQ-011 stall  output  6  per-stage stop; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1=Stop.
REQ-012 flush  output  1  kill IF/ID contents this cycle.
REQ-013 stall_cycles  output  32  count of cycles with stall!=0.

Function
REQ-014 Arbiter FSM states SHALL be IDLE, GNT_IF, GNT_MEM; grant_if=1 only in GNT_IF, grant_mem=1 only in GNT_MEM.
REQ-015 From IDLE: mem_req -> GNT_MEM; else if_req -> GNT_IF; else stay IDLE (MEM priority).
REQ-016 In GNT_x without bus_ack the FSM SHALL hold; grant never changes mid-transaction regardless of requests.
REQ-017 In GNT_x with bus_ack the FSM SHALL re-arbitrate per REQ-015 that edge (back-to-back, no idle cycle).
REQ-018 bus_ack while IDLE SHALL be ignored.
REQ-019 mem_wait = mem_req && !(GNT_MEM && bus_ack); if_wait = if_req && !(GNT_IF && bus_ack).
REQ-020 stall SHALL be combinational, priority order: mem_wait 6'b011111; stallreq_ex 6'b001111; stallreq_id 6'b000111; if_wait 6'b000011; else 6'b000000.
REQ-021 flush = branch_flag && !mem_wait && !stallreq_ex; flush with stallreq_id/if_wait simultaneously SHALL still assert (branch overrides younger stages).
REQ-022 Latency: a request completing with bus_ack releases stall in the same cycle as the ack.
REQ-023 stall_cycles SHALL increment by 1 per edge where stall!=0, saturating at 32'hFFFFFFFF.

Reset
REQ-024 rst low SHALL force FSM to IDLE, grant_if=0, grant_mem=0, stall=6'b0, flush=0, stall_cycles=0, immediately and asynchronously.
REQ-025 Reset mid-transaction SHALL abandon the grant; first post-reset edge arbitrates from IDLE.

Configuration
REQ-026 Macro PIPE_CTRL_PERF_EN: defined -> stall_cycles counter per REQ-023; undefined -> no counter flops, stall_cycles constant 32'h0, port retained.

Structure
REQ-027 Shared defines header SHALL hold stall width/bit indices, Stop/NoStop, RstEnable, FSM state encodings.
REQ-028 Arbiter FSM SHALL be sub-module mem_port_arb (REQ-014..018); stall/flush/counter logic in top.

Verification
REQ-029 if_req=1,mem_req=1 from IDLE -> next cycle grant_mem=1, stall=6'b011111; ack -> grant_if=1, stall=6'b000011.
REQ-030 GNT_IF held 3 cycles, mem_req rises cycle 1 -> grant_if stays 1, stall=6'b011111 until ack, then grant_mem=1.
REQ-031 stallreq_id=1 and branch_flag=1, no mem activity -> stall=6'b000111, flush=1; add stallreq_ex=1 -> stall=6'b001111, flush=0.
REQ-032 rst low during GNT_MEM -> grants 0, stall 0 immediately; rst high, mem_req=1 -> GNT_MEM after one edge.
REQ-033 PERF_EN defined, stall nonzero 5 cycles -> stall_cycles=5; preload near max -> holds 32'hFFFFFFFF; undefined -> always 0.
